// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the raw pins, then
// deserializes start/8 data/odd parity/stop frames into a byte plus strobe.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 10000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] ps2_data,
    output logic       ps2_data_clk,
    output logic       ps2_error
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [7:0]  FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    logic        clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic [7:0]  filt_cnt_q, filt_cnt_d;
    logic        clk_f_q, clk_f_d, clk_f_prev_q;
    logic [15:0] to_cnt_q, to_cnt_d;
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [7:0]  data_q, data_d;
    logic        strobe_q, strobe_d;
    logic        err_q, err_d;
    logic        fall;
    logic        timed_out;

    assign fall      = clk_f_prev_q & ~clk_f_q;
    assign timed_out = (state_q != IDLE) && !fall && (to_cnt_q == TO_LAST);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        filt_cnt_d = '0;
        clk_f_d    = clk_f_q;
        if (clk_sync_q != clk_f_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                clk_f_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        to_cnt_d = to_cnt_q + 16'd1;
        if (state_q == IDLE || fall || timed_out) begin
            to_cnt_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        strobe_d  = 1'b0;
        err_d     = 1'b0;
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    // A high data line at a falling edge is a stray edge, not a start bit.
                    if (!dat_sync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat_sync_q;
                    state_d = STOP;
                end
                STOP: begin
                    if (dat_sync_q && (^shift_q ^ par_q)) begin
                        data_d   = shift_q;
                        strobe_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (timed_out) begin
            state_d = IDLE;
            shift_d = '0;
            err_d   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            dat_meta_q   <= 1'b1;
            dat_sync_q   <= 1'b1;
            filt_cnt_q   <= '0;
            clk_f_q      <= 1'b1;
            clk_f_prev_q <= 1'b1;
            to_cnt_q     <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            data_q       <= 8'h00;
            strobe_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            clk_meta_q   <= ps2_clk;
            clk_sync_q   <= clk_meta_q;
            dat_meta_q   <= ps2_dat;
            dat_sync_q   <= dat_meta_q;
            filt_cnt_q   <= filt_cnt_d;
            clk_f_q      <= clk_f_d;
            clk_f_prev_q <= clk_f_q;
            to_cnt_q     <= to_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            data_q       <= data_d;
            strobe_q     <= strobe_d;
            err_q        <= err_d;
        end
    end

    assign ps2_data     = data_q;
    assign ps2_data_clk = strobe_q;
    assign ps2_error    = err_q;

endmodule
